// File: rtl/board_supervisor_pkg.sv
// Shared board definitions: state encodings and counter sizing helpers.
package board_supervisor_pkg;

  localparam int BOARD_BITS = 2;

  typedef enum logic [BOARD_BITS-1:0] {
    BOARD_IDLE     = 2'd0,
    BOARD_STARTUP  = 2'd1,
    BOARD_RUNNING  = 2'd2,
    BOARD_SHUTDOWN = 2'd3
  } board_state_e;

  // Bits needed to hold the values 0..max.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/board_supervisor_edge_rise.sv
// 1-bit rising-edge detector; history clears to 0 so a level already high
// after reset reports one edge.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev_q;

  // Register the previous sample of the input.
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/board_supervisor.sv
// Board supervisor: IDLE/STARTUP/RUNNING/SHUTDOWN sequencer with subsystem
// ready gating, startup timeout fault, timed shutdown, guarded arming and
// radio-loss failsafe. All outputs are registered.
module board_supervisor
  import board_supervisor_pkg::*;
#(
  parameter int TS_WIDTH        = 24,
  parameter int NUM_SUB         = 4,
  parameter int STARTUP_TIMEOUT = 500,
  parameter int SHUTDOWN_TICKS  = 100,
  parameter int FAILSAFE_TICKS  = 250,
  parameter int AUTOSTART       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  start_req,
  input  logic                  shutdown_req,
  input  logic                  arm_req,
  input  logic                  throttle_low,
  input  logic                  radio_ok,
  input  logic [NUM_SUB-1:0]    sub_ready,
  output logic [BOARD_BITS-1:0] state,
  output logic                  sub_rst,
  output logic                  motor_en,
  output logic [TS_WIDTH-1:0]   timestamp,
  output logic                  fault,
  output logic                  failsafe
);

  localparam int TICK_MAX = (STARTUP_TIMEOUT > SHUTDOWN_TICKS) ? STARTUP_TIMEOUT : SHUTDOWN_TICKS;
  localparam int TICK_W   = cnt_w(TICK_MAX);
  localparam int LOSS_W   = cnt_w(FAILSAFE_TICKS);

  localparam logic [TICK_W-1:0] TO_CNT   = TICK_W'(STARTUP_TIMEOUT);
  localparam logic [TICK_W-1:0] SD_CNT   = TICK_W'(SHUTDOWN_TICKS);
  localparam logic [LOSS_W-1:0] FS_CNT   = LOSS_W'(FAILSAFE_TICKS);
  localparam logic [LOSS_W-1:0] FS_LAST  = LOSS_W'(FAILSAFE_TICKS - 1);

  logic start_rise, arm_rise, sd_rise;

  edge_rise u_start (.clk(clk), .rst_n(rst_n), .d(start_req),    .rise(start_rise));
  edge_rise u_arm   (.clk(clk), .rst_n(rst_n), .d(arm_req),      .rise(arm_rise));
  edge_rise u_sd    (.clk(clk), .rst_n(rst_n), .d(shutdown_req), .rise(sd_rise));

  board_state_e        state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                motor_q, motor_d;
  logic                fault_q, fault_d;
  logic                fs_q, fs_d;
  logic                sub_rst_q, sub_rst_d;
  logic                fs_hit;

  // Next-state, counter and output decisions for the sequencer.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    loss_cnt_d = '0;
    ts_d       = ts_q;
    motor_d    = motor_q;
    fault_d    = fault_q;
    fs_d       = 1'b0;
    fs_hit     = 1'b0;

    case (state_q)
      BOARD_IDLE: begin
        motor_d = 1'b0;
        ts_d    = '0;
        if (!fault_q && ((AUTOSTART != 0) || start_rise)) state_d = BOARD_STARTUP;
      end
      BOARD_STARTUP: begin
        // Ready beats a coincident timeout.
        if (&sub_ready) begin
          state_d = BOARD_RUNNING;
        end else if (tick_cnt_q == TO_CNT) begin
          fault_d = 1'b1;
          state_d = BOARD_SHUTDOWN;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
      BOARD_RUNNING: begin
        loss_cnt_d = loss_cnt_q;
        if (tick) ts_d = ts_q + TS_WIDTH'(1);
        if (sd_rise) begin
          state_d = BOARD_SHUTDOWN;
          motor_d = 1'b0;
        end else begin
          // Loss counter parks at the limit so the pulse fires once per outage.
          fs_hit = tick && !radio_ok && (loss_cnt_q == FS_LAST);
          if (radio_ok)                             loss_cnt_d = '0;
          else if (tick && (loss_cnt_q != FS_CNT))  loss_cnt_d = loss_cnt_q + LOSS_W'(1);
          if (fs_hit) begin
            motor_d = 1'b0;
            fs_d    = 1'b1;
          end else if (arm_rise) begin
            motor_d = motor_q ? 1'b0 : (throttle_low && radio_ok);
          end
        end
      end
      BOARD_SHUTDOWN: begin
        motor_d = 1'b0;
        if (tick_cnt_q == SD_CNT) begin
          state_d = BOARD_IDLE;
          ts_d    = '0;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
      default: begin
        state_d = BOARD_IDLE;
        motor_d = 1'b0;
      end
    endcase

    if (state_d != state_q) tick_cnt_d = '0;
    sub_rst_d = (state_d == BOARD_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOARD_IDLE;
      tick_cnt_q <= '0;
      loss_cnt_q <= '0;
      ts_q       <= '0;
      motor_q    <= 1'b0;
      fault_q    <= 1'b0;
      fs_q       <= 1'b0;
      sub_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      ts_q       <= ts_d;
      motor_q    <= motor_d;
      fault_q    <= fault_d;
      fs_q       <= fs_d;
      sub_rst_q  <= sub_rst_d;
    end
  end

  assign state     = state_q;
  assign sub_rst   = sub_rst_q;
  assign motor_en  = motor_q;
  assign timestamp = ts_q;
  assign fault     = fault_q;
  assign failsafe  = fs_q;

endmodule
